// File: rtl/multi_writer_reg_bank.sv
// Channel register bank with several write ports, arbitration,
// and synchronized per-channel set/clear requests.
module multi_writer_reg_bank #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int NPORT = 2,
  parameter int RR    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORT-1:0]             wr_vld,
  input  logic [NPORT*$clog2(NCH)-1:0] wr_addr,
  input  logic [NPORT*WIDTH-1:0]       wr_data,
  input  logic [NCH-1:0]               set_req,
  input  logic [NCH-1:0]               clr_req,
  output logic [NCH*WIDTH-1:0]         q,
  output logic [NPORT-1:0]             grant,
  output logic                         collide,
  output logic [7:0]                   collide_cnt
);

  localparam int AW = $clog2(NCH);
  localparam int PW = $clog2(NPORT);

  logic [NCH-1:0] s1_q, s1_d, s2_q, s2_d, sh_q, sh_d;
  logic [NCH-1:0] c1_q, c1_d, c2_q, c2_d, chh_q, chh_d;
  logic [NCH*WIDTH-1:0] q_q, q_d;
  logic [NPORT-1:0] grant_q, grant_d;
  logic collide_q, collide_d;
  logic [7:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic [NCH-1:0] set_e, clr_e, ch_wr, ch_col;
  logic [PW-1:0] win [NCH];
  int hits;
  int idx;

  always_comb begin
    s1_d  = set_req;
    s2_d  = s1_q;
    sh_d  = s2_q;
    c1_d  = clr_req;
    c2_d  = c1_q;
    chh_d = c2_q;
    set_e = s2_q & ~sh_q;
    clr_e = c2_q & ~chh_q;

    ch_wr  = '0;
    ch_col = '0;
    hits   = 0;
    idx    = 0;
    for (int c = 0; c < NCH; c++) begin
      hits   = 0;
      win[c] = '0;
      // Scan order encodes the arbitration policy: first hit wins.
      for (int k = 0; k < NPORT; k++) begin
        idx = (RR != 0) ? (int'(ptr_q) + k) % NPORT : k;
        if (wr_vld[idx] && wr_addr[idx*AW +: AW] == AW'(c)) begin
          if (hits == 0) win[c] = PW'(idx);
          hits = hits + 1;
        end
      end
      ch_wr[c]  = hits > 0;
      ch_col[c] = hits > 1;
    end

    q_d     = q_q;
    grant_d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (clr_e[c]) begin
        q_d[c*WIDTH +: WIDTH] = '0;
      end else if (set_e[c]) begin
        q_d[c*WIDTH +: WIDTH] = '1;
      end else if (ch_wr[c]) begin
        q_d[c*WIDTH +: WIDTH] = wr_data[int'(win[c])*WIDTH +: WIDTH];
        grant_d[win[c]] = 1'b1;
      end
    end

    // Lowest colliding channel decides the pointer move.
    ptr_d = ptr_q;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (RR != 0 && ch_col[c]) ptr_d = PW'((int'(win[c]) + 1) % NPORT);
    end

    collide_d = |ch_col;
    cnt_d = (collide_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      sh_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      chh_q     <= '0;
      q_q       <= '0;
      grant_q   <= '0;
      collide_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      sh_q      <= sh_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      chh_q     <= chh_d;
      q_q       <= q_d;
      grant_q   <= grant_d;
      collide_q <= collide_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign q           = q_q;
  assign grant       = grant_q;
  assign collide     = collide_q;
  assign collide_cnt = cnt_q;

endmodule

// File: tb/tb_multi_writer_reg_bank.sv
// Scoreboard bench for multi_writer_reg_bank, fixed-priority and
// round-robin instances driven by the same stimulus.
module tb_multi_writer_reg_bank;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int P  = 2;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [P-1:0]    wr_vld  = '0;
  logic [P*AW-1:0] wr_addr = '0;
  logic [P*W-1:0]  wr_data = '0;
  logic [N-1:0]    set_req = '0;
  logic [N-1:0]    clr_req = '0;

  logic [N*W-1:0] q0, q1;
  logic [P-1:0]   g0, g1;
  logic           c0, c1;
  logic [7:0]     n0, n1;

  multi_writer_reg_bank #(.WIDTH(W), .NCH(N), .NPORT(P), .RR(0)) u0 (
    .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_addr(wr_addr),
    .wr_data(wr_data), .set_req(set_req), .clr_req(clr_req),
    .q(q0), .grant(g0), .collide(c0), .collide_cnt(n0)
  );

  multi_writer_reg_bank #(.WIDTH(W), .NCH(N), .NPORT(P), .RR(1)) u1 (
    .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_addr(wr_addr),
    .wr_data(wr_data), .set_req(set_req), .clr_req(clr_req),
    .q(q1), .grant(g1), .collide(c1), .collide_cnt(n1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          inst;
    int          sel;
    int          ch;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int inst, input int sel,
                                      input int ch);
    logic [31:0] r;
    r = '0;
    case (sel)
      0: r = (inst == 0) ? 32'(q0[ch*W +: W]) : 32'(q1[ch*W +: W]);
      1: r = (inst == 0) ? 32'(g0) : 32'(g1);
      2: r = (inst == 0) ? 32'(c0) : 32'(c1);
      default: r = (inst == 0) ? 32'(n0) : 32'(n1);
    endcase
    return r;
  endfunction

  task automatic ex(input string tag, input int inst, input int sel,
                    input int ch, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.inst = inst;
    e.sel  = sel;
    e.ch   = ch;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic ex2(input string tag, input int sel, input int ch,
                     input logic [31:0] v);
    ex({tag, "_fp"}, 0, sel, ch, v);
    ex({tag, "_rr"}, 1, sel, ch, v);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.inst, e.sel, e.ch), e.exp);
    end
  endtask

  task automatic wr(input int p, input int a, input logic [7:0] d);
    wr_vld[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*W +: W] = d;
  endtask

  task automatic all_zero(input string tag);
    for (int c = 0; c < N; c++) ex2({tag, "_q"}, 0, c, 0);
    ex2({tag, "_grant"}, 1, 0, 0);
    ex2({tag, "_collide"}, 2, 0, 0);
    ex2({tag, "_cnt"}, 3, 0, 0);
  endtask

  initial begin
    all_zero("rst");
    step();
    rst = 1'b1;

    wr(0, 1, 8'h5A);
    wr(1, 2, 8'hC3);
    ex2("par_ch1", 0, 1, 32'h5A);
    ex2("par_ch2", 0, 2, 32'hC3);
    ex2("par_grant", 1, 0, 32'h3);
    ex2("par_collide", 2, 0, 0);
    step();

    wr(0, 0, 8'h11);
    wr(1, 0, 8'h22);
    ex2("fp_ch0", 0, 0, 32'h11);
    ex2("fp_grant", 1, 0, 32'h1);
    ex2("fp_collide", 2, 0, 1);
    ex2("fp_cnt", 3, 0, 1);
    step();
    wr_vld = '0;
    ex2("fp_pulse_end", 2, 0, 0);
    ex2("fp_grant_idle", 1, 0, 0);
    step();

    rst = 1'b0;
    all_zero("rst2");
    step();
    rst = 1'b1;

    for (int k = 0; k < 3; k++) begin
      wr(0, 1, 8'hA0);
      wr(1, 1, 8'hB0);
      ex("rr_ch1", 1, 0, 1, (k == 1) ? 32'hB0 : 32'hA0);
      ex("rr_grant", 1, 1, 0, (k == 1) ? 32'h2 : 32'h1);
      ex("rr_fp_ch1", 0, 0, 1, 32'hA0);
      ex2("rr_collide", 2, 0, 1);
      step();
    end
    wr_vld = '0;
    ex2("rr_cnt", 3, 0, 3);
    step();

    set_req[3] = 1'b1;
    step();
    ex2("set_e2_ch3", 0, 3, 0);
    step();
    wr(0, 3, 8'h0F);
    ex2("set_ch3", 0, 3, 32'hFF);
    ex2("set_grant", 1, 0, 0);
    ex2("set_cnt", 3, 0, 3);
    step();
    wr_vld = '0;
    ex2("set_hold", 0, 3, 32'hFF);
    step();
    set_req[3] = 1'b0;
    step();
    step();
    step();
    set_req[3] = 1'b1;
    clr_req[3] = 1'b1;
    step();
    ex2("clr_e2_ch3", 0, 3, 32'hFF);
    step();
    ex2("clr_ch3", 0, 3, 0);
    step();
    set_req = '0;
    clr_req = '0;

    for (int k = 1; k <= 260; k++) begin
      wr(0, 0, 8'h01);
      wr(1, 0, 8'h02);
      if (k == 252 || k == 260) ex2("sat_cnt", 3, 0, 255);
      if (k == 260) ex2("sat_collide", 2, 0, 1);
      step();
    end
    wr_vld = '0;
    rst = 1'b0;
    all_zero("rst3");
    step();

    wr(0, 0, 8'h77);
    clr_req[0] = 1'b1;
    ex2("rstwr_ch0", 0, 0, 0);
    ex2("rstwr_grant", 1, 0, 0);
    step();
    rst = 1'b1;
    ex2("rel_e1_ch0", 0, 0, 32'h77);
    step();
    wr_vld = '0;
    ex2("rel_e2_ch0", 0, 0, 32'h77);
    step();
    ex2("rel_e3_ch0", 0, 0, 0);
    step();
    wr(0, 0, 8'h66);
    ex2("rel_e4_ch0", 0, 0, 32'h66);
    step();
    wr_vld = '0;
    ex2("rel_e5_ch0", 0, 0, 32'h66);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
